// File: rtl/sg_scan_scheduler.sv
// SpikeGenerator scan scheduler: owns the generator program memory, runs one
// countdown scan per time-unit pulse and arbitrates memory access with program writes.
module sg_scan_scheduler #(
    parameter int N_SG_gens   = 8,
    parameter int N_SG_period = 16,
    parameter int N_SG_tag    = 11
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [N_SG_gens+2*N_SG_period+N_SG_tag-1:0] prog_d,
    input  logic                                       prog_v,
    output logic                                       prog_a,
    input  logic [N_SG_gens-1:0]                       gens_used,
    input  logic [(1<<N_SG_gens)-1:0]                  gens_en,
    input  logic                                       time_unit,
    output logic [N_SG_tag-1:0]                        out_tag,
    output logic [N_SG_gens-1:0]                       out_gen_idx,
    output logic                                       out_v,
    input  logic                                       out_a,
    output logic                                       busy,
    output logic                                       overrun
);

    // state | meaning
    // IDLE  | accept program writes, wait for a time-unit pulse
    // READ  | issue synchronous read of mem[idx]
    // EVAL  | decide skip / decrement / fire on the read data
    // EMIT  | present spike until accepted
    // WRITE | write back updated ticks, then move to next generator

    localparam int NG = 1 << N_SG_gens;
    localparam int W  = 2*N_SG_period + N_SG_tag;

    typedef enum logic [2:0] {IDLE, READ, EVAL, EMIT, WRITE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]           mem [NG];
    logic [W-1:0]           rd_q;
    logic                   mem_we, mem_re;
    logic [N_SG_gens-1:0]   mem_wa;
    logic [W-1:0]           mem_wd;

    logic [N_SG_gens-1:0]   idx, scan_end;
    logic [N_SG_period-1:0] new_ticks;
    logic                   pending;

    logic [N_SG_gens-1:0]   prog_gen;
    logic [N_SG_period-1:0] rd_period, rd_ticks;
    logic [N_SG_tag-1:0]    rd_tag;
    logic                   start_req, scan_start, last, eval_skip, eval_fire, advance;

    assign prog_gen  = prog_d[W +: N_SG_gens];
    assign rd_period = rd_q[W-1 -: N_SG_period];
    assign rd_ticks  = rd_q[N_SG_tag +: N_SG_period];
    assign rd_tag    = rd_q[N_SG_tag-1:0];

    assign last       = (idx == scan_end);
    assign start_req  = (pending || time_unit) && (gens_used != '0);
    assign scan_start = (state == IDLE) && !prog_a && start_req;
    assign eval_skip  = !gens_en[idx] || (rd_period == '0);
    assign eval_fire  = !eval_skip && (rd_ticks <= N_SG_period'(1));
    assign advance    = ((state == EVAL) && eval_skip && !last) || ((state == WRITE) && !last);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (scan_start) state_nxt = READ;
            READ:  state_nxt = EVAL;
            EVAL: begin
                if (eval_skip)      state_nxt = last ? IDLE : READ;
                else if (eval_fire) state_nxt = EMIT;
                else                state_nxt = WRITE;
            end
            EMIT:  if (out_a) state_nxt = WRITE;
            WRITE: state_nxt = last ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes are gated by reset so a reset landing mid-scan never commits ticks.
    always_comb begin
        prog_a = reset && (state == IDLE) && prog_v;
        out_v  = (state == EMIT);
        busy   = (state != IDLE);
        mem_re = (state == READ);
        mem_we = 1'b0;
        mem_wa = idx;
        mem_wd = {rd_period, new_ticks, rd_tag};
        if (prog_a) begin
            mem_we = 1'b1;
            mem_wa = prog_gen;
            mem_wd = prog_d[W-1:0];
        end else if (reset && (state == WRITE)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (mem_re) rd_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx         <= '0;
            scan_end    <= '0;
            new_ticks   <= '0;
            out_tag     <= '0;
            out_gen_idx <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (scan_start) begin
                scan_end <= gens_used - N_SG_gens'(1);
                idx      <= '0;
            end else if (advance) begin
                idx <= idx + N_SG_gens'(1);
            end

            if (state == EVAL && !eval_skip) begin
                if (eval_fire) begin
                    new_ticks   <= rd_period;
                    out_tag     <= rd_tag;
                    out_gen_idx <= idx;
                end else begin
                    new_ticks <= rd_ticks - N_SG_period'(1);
                end
            end

            // A pulse that cannot start a scan right now is remembered once; a second one is an overrun.
            if (scan_start) begin
                pending <= 1'b0;
            end else if (time_unit && (state != IDLE || prog_a)) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sg_scan_scheduler.sv
// Self-checking bench for sg_scan_scheduler: directed scenarios with a spike
// scoreboard checked by an independent monitor.
module tb_sg_scan_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [50:0]  prog_d;
    logic         prog_v;
    logic         prog_a;
    logic [7:0]   gens_used;
    logic [255:0] gens_en;
    logic         time_unit;
    logic [10:0]  out_tag;
    logic [7:0]   out_gen_idx;
    logic         out_v;
    logic         out_a;
    logic         busy;
    logic         overrun;

    int n_vec  = 0;
    int n_miss = 0;
    logic [18:0] sb [$];

    always #5 clk = ~clk;

    sg_scan_scheduler dut (
        .clk(clk), .reset(reset), .prog_d(prog_d), .prog_v(prog_v), .prog_a(prog_a),
        .gens_used(gens_used), .gens_en(gens_en), .time_unit(time_unit),
        .out_tag(out_tag), .out_gen_idx(out_gen_idx), .out_v(out_v), .out_a(out_a),
        .busy(busy), .overrun(overrun)
    );

    // Spike monitor: every accepted spike must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && out_v && out_a) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_spike: got gen %0d tag %0h, none expected", out_gen_idx, out_tag);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                if ({out_gen_idx, out_tag} !== e) begin
                    n_miss++;
                    $display("FAIL spike: got gen %0d tag %0h, expected gen %0d tag %0h",
                             out_gen_idx, out_tag, e[18:11], e[10:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic prog(input logic [7:0] g, input logic [15:0] p, input logic [15:0] t, input logic [10:0] tg);
        logic ok;
        ok = 1'b0;
        prog_d = {g, p, t, tg};
        prog_v = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (prog_a) begin ok = 1'b1; break; end
        end
        chk("prog_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        prog_v = 1'b0;
    endtask

    task automatic pulse();
        time_unit = 1'b1;
        @(posedge clk); #1;
        time_unit = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        chk("scan_end_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_out_v(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_v) begin ok = 1'b1; break; end
        end
        chk("out_v_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_scan(input string name);
        pulse();
        wait_idle(1000);
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // After an overrun/pending scan: one immediate rescan, then quiet.
    task automatic check_one_rescan();
        wait_idle(2000);
        @(negedge clk);
        chk("rescan_started", 32'(busy), 32'd1);
        wait_idle(2000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_second_rescan", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; prog_d = '0; prog_v = 1'b0; gens_used = '0; gens_en = '0;
        time_unit = 1'b0; out_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_out_v",   32'(out_v),       32'd0);
        chk("rst_prog_a",  32'(prog_a),      32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        chk("rst_out_tag", 32'(out_tag),     32'd0);
        chk("rst_out_gen", 32'(out_gen_idx), 32'd0);

        // Gen 3 {period 4, ticks 2}: fires on pulses 2, 6, 10.
        @(posedge clk); #1;
        gens_used = 8'd4;
        gens_en = 256'd1 << 3;
        prog(8'd3, 16'd4, 16'd2, 11'h155);
        for (int k = 1; k <= 10; k++) begin
            if (k == 2 || k == 6 || k == 10) sb.push_back({8'd3, 11'h155});
            pulse_scan("t1_spikes_pending");
        end

        // Two period-1 generators: gen 0 then gen 1 every pulse; first out_v at t+3.
        gens_used = 8'd2;
        gens_en = 256'd3;
        prog(8'd0, 16'd1, 16'd1, 11'h011);
        prog(8'd1, 16'd1, 16'd1, 11'h022);
        sb.push_back({8'd0, 11'h011});
        sb.push_back({8'd1, 11'h022});
        pulse();
        @(negedge clk);
        @(negedge clk);
        chk("out_v_before_t3", 32'(out_v), 32'd0);
        @(negedge clk);
        chk("out_v_at_t3", 32'(out_v), 32'd1);
        wait_idle(100);
        chk("t2_pulse1", 32'(sb.size()), 32'd0);
        for (int k = 0; k < 2; k++) begin
            sb.push_back({8'd0, 11'h011});
            sb.push_back({8'd1, 11'h022});
            pulse_scan("t2_pulses");
        end

        // Backpressure for 20 cycles with a program word waiting.
        gens_used = 8'd6;
        gens_en = 256'd1 << 5;
        prog(8'd5, 16'd2, 16'd1, 11'h3AA);
        out_a = 1'b0;
        sb.push_back({8'd5, 11'h3AA});
        pulse();
        wait_out_v(20);
        prog_d = {8'd7, 16'd9, 16'd9, 11'h001};
        prog_v = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_v",    32'(out_v),   32'd1);
            chk("bp_out_tag",  32'(out_tag), 32'h3AA);
            chk("bp_busy",     32'(busy),    32'd1);
            chk("bp_no_prog_a", 32'(prog_a), 32'd0);
        end
        @(posedge clk); #1;
        out_a = 1'b1;
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (prog_a) begin ok = 1'b1; break; end
            end
            chk("bp_prog_accept", 32'(ok), 32'd1);
            chk("bp_accept_when_idle", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        prog_v = 1'b0;
        chk("bp_spike_done", 32'(sb.size()), 32'd0);

        // Simultaneous program write and pulse: write first, scan uses new ticks.
        gens_used = 8'd3;
        gens_en = 256'd1 << 2;
        prog(8'd2, 16'd5, 16'd5, 11'h0F0);
        prog_d = {8'd2, 16'd5, 16'd1, 11'h0F0};
        prog_v = 1'b1;
        time_unit = 1'b1;
        sb.push_back({8'd2, 11'h0F0});
        @(negedge clk);
        chk("sim_prog_a", 32'(prog_a), 32'd1);
        @(posedge clk); #1;
        prog_v = 1'b0;
        time_unit = 1'b0;
        @(negedge clk);
        chk("sim_idle_after_write", 32'(busy), 32'd0);
        @(negedge clk);
        chk("sim_scan_started", 32'(busy), 32'd1);
        wait_idle(100);
        chk("sim_fired_new_ticks", 32'(sb.size()), 32'd0);

        // Reset during EMIT: output drops, ticks stay at 1 so the next pulse fires again.
        gens_used = 8'd1;
        gens_en = 256'd1;
        prog(8'd0, 16'd3, 16'd1, 11'h7FF);
        out_a = 1'b0;
        pulse();
        wait_out_v(20);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        out_a = 1'b1;
        @(negedge clk);
        chk("rst_emit_out_v", 32'(out_v), 32'd0);
        chk("rst_emit_busy",  32'(busy),  32'd0);
        sb.push_back({8'd0, 11'h7FF});
        pulse_scan("rst_ticks_unchanged");
        pulse_scan("rst_dec1");
        pulse_scan("rst_dec2");
        sb.push_back({8'd0, 11'h7FF});
        pulse_scan("rst_refire");

        // Overrun: two extra pulses during a 200-generator scan.
        apply_reset();
        gens_used = 8'd200;
        gens_en = '0;
        pulse();
        repeat (3) @(posedge clk);
        #1;
        pulse();
        repeat (3) @(posedge clk);
        #1;
        pulse();
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        check_one_rescan();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // One extra pulse: pending only, no overrun.
        apply_reset();
        pulse();
        repeat (5) @(posedge clk);
        #1;
        pulse();
        check_one_rescan();
        chk("single_extra_no_overrun", 32'(overrun), 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sg_scan_scheduler.md
# sg_scan_scheduler

Time-unit-driven scheduler that owns the SpikeGenerator program memory and sequences it. Each time-unit pulse triggers one scan over generators 0..gens_used-1: the block reads each generator's {period, ticks, tag}, decrements ticks, and emits the tag on the spike output channel when the countdown expires. It arbitrates the memory between that scan and the deserialized program-write channel from the PC configuration path, and takes its gens_used/gens_en configuration from the SpikeGenerator configuration registers.

## Interface
- N_SG_gens, 8, generator index width; memory depth NG = 2**N_SG_gens
- N_SG_period, 16, period and ticks width
- N_SG_tag, 11, tag width

- clk  in  1  clock
- reset  in  1  synchronous, active-low (asserted when 0)
- prog_d  in  N_SG_gens+2*N_SG_period+N_SG_tag  {gen_idx, period, ticks, tag}, MSB first
- prog_v  in  1  program word valid
- prog_a  out  1  program word accepted; transfer when prog_v && prog_a
- gens_used  in  N_SG_gens  number of generators scanned; 0 means none
- gens_en  in  NG  per-generator enable, bit i = generator i
- time_unit  in  1  single-cycle time-unit pulse
- out_tag  out  N_SG_tag  emitted tag
- out_gen_idx  out  N_SG_gens  generator that fired
- out_v  out  1  spike valid
- out_a  in  1  spike accept; transfer when out_v && out_a
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; set when a time_unit arrives while a pulse is already pending

## Operation
- Internal memory: NG entries of {period, ticks, tag}, 1-cycle synchronous read. Contents are undefined after reset; safety comes from gens_en resetting to 0 upstream.
- States: IDLE, READ, EVAL, EMIT, WRITE.
- IDLE
  - prog_a = prog_v.
  - On a program transfer, write mem[gen_idx] = {period, ticks, tag}. The state stays IDLE.
  - Else, if pending or time_unit, and gens_used != 0: latch scan_end = gens_used-1, idx = 0, clear pending, go to READ.
  - time_unit with gens_used == 0 is dropped.
- READ: issue read of mem[idx], go to EVAL.
- EVAL, using the read data:
  - Generator disabled (gens_en[idx] == 0) or period == 0: no write, go to next.
  - Otherwise, if ticks <= 1: fire. Set new_ticks = period, load out_tag/out_gen_idx, go to EMIT.
  - Otherwise: new_ticks = ticks-1, go to WRITE.
- EMIT: out_v = 1, with data held stable, until out_a. On the transfer, go to WRITE.
- WRITE: mem[idx].ticks = new_ticks; period and tag are unchanged. Go to next.
- next: if idx == scan_end, go to IDLE; else idx += 1, go to READ.
- gens_used is sampled once at scan start. gens_en is sampled in EVAL.
- time_unit in any non-IDLE state, or in the same cycle as an IDLE program transfer:
  - If pending == 0, set pending.
  - Else set overrun.
- Program writes are never accepted while busy. prog_a = 0 outside IDLE.
- Arithmetic is unsigned. ticks wraps are impossible because ticks <= 1 reloads.

## Timing
- Reset values: state IDLE, out_v 0, prog_a 0, busy 0, overrun 0, pending 0, idx 0, out_tag 0, out_gen_idx 0.
- Reset mid-scan: return to IDLE the next cycle. Any in-flight WRITE is suppressed; a held out_v drops.
- time_unit in IDLE at cycle t: READ at t+1, EVAL at t+2.
- Per-generator cost:
  - Disabled or period 0: 2 cycles.
  - Decrement: 3 cycles.
  - Fire: 4 cycles with out_a tied high, plus backpressure stall cycles.
- Earliest out_v is cycle t+3 after the triggering pulse.
- A pending pulse starts the next scan on the cycle after the return to IDLE, unless a program transfer is in progress in that cycle; program writes take priority in IDLE.
- A read in the cycle after an IDLE program write to the same index returns the new data.
- prog_a and out_v are registered/combinational as described. out_d changes only when out_v is low or on a transfer.

## Test plan
- Program gen 3 with {period=4, ticks=2, tag=0x155}, gens_used=4, gens_en bit 3 only, 10 pulses:
  - Spikes (gen 3, tag 0x155) after pulses 2, 6 and 10.
  - No spikes from gens 0-2.
- Gen 0 with period=1 and gen 1 with period=1, both enabled, gens_used=2, 3 pulses:
  - Each pulse emits gen 0 then gen 1, in that order: 6 spikes total.
- Backpressure: hold out_a low for 20 cycles during a fire.
  - out_v stays high with out_tag stable.
  - busy stays high.
  - prog_v with a program word is not accepted until the scan ends.
- Overrun:
  - Pulse in IDLE, then 2 more pulses during the same scan with gens_used=200: overrun=1.
  - Exactly one back-to-back rescan follows.
  - A single extra pulse leaves overrun=0.
- Simultaneous time_unit and prog_v in IDLE:
  - The write is accepted first.
  - The scan starts the next cycle and uses the newly written ticks.
- Reset (reset=0 for 1 cycle) during EMIT:
  - Next cycle out_v=0, busy=0.
  - That generator's ticks is unchanged in memory.
